// File: rtl/ysyx_22050854_imem_resp.sv
// ============================================================================
// Module   : ysyx_22050854_imem_resp
// Brief    : Instruction-memory responder with a fixed-latency valid/ready
//            fetch port and a side-band program-load write port. It holds at
//            most one fetch in flight. Fetches outside the stored window
//            return ebreak.
// Options  : define YSYX_22050854_IMEM_MISALIGN_CHK_EN to fault misaligned
//            fetch addresses (resp_err = 1, resp_inst = 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050854_imem_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [31:0]           req_pc,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_inst,
    output logic                  resp_err,
    input  logic                  prog_wen,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [31:0]           prog_data,
    output logic [31:0]           fetch_cnt
);

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  WAIT      = 2'd1;
    localparam logic [1:0]  RESP      = 2'd2;
    localparam logic [31:0] EBREAK    = 32'h00100073;
    // The window is word aligned, so comparisons are done on word addresses.
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [3:0]  LAT_INIT  = 4'(LATENCY - 1);

    logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];

    logic [1:0]            state;
    logic [3:0]            lat_cnt;
    logic [31:0]           inst_q;
    logic                  err_q;

    logic [29:0]           word_off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  misaligned;
    logic [31:0]           fetch_data;

    // The word offset wraps for addresses below BASE_ADDR, so those fall out of range as well.
    assign word_off = req_pc[31:2] - BASE_WORD;
    assign in_range = (word_off[29:DEPTH_LOG2] == '0);
    assign word_idx = word_off[DEPTH_LOG2-1:0];

`ifdef YSYX_22050854_IMEM_MISALIGN_CHK_EN
    assign misaligned = (req_pc[1:0] != 2'b00);
`else
    // Byte-offset bits are ignored: the fetch behaves as if they were 00.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^req_pc[1:0];
    assign misaligned    = 1'b0;
`endif

    // Select the word to capture at the accept edge. A misaligned fetch has priority over the range check.
    always_comb begin
        fetch_data = '0;
        if (misaligned) begin
            fetch_data = '0;
        end else if (in_range) begin
            fetch_data = mem[word_idx];
        end else begin
            fetch_data = EBREAK;
        end
    end

    // Program-load port runs independently of the fetch FSM and is untouched by reset.
    always_ff @(posedge clk) begin
        if (prog_wen) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Fetch FSM: capture at accept, count down the latency, hold until the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            inst_q    <= '0;
            err_q     <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // The memory write on the same edge lands after this read, so the old word is returned.
                        inst_q  <= fetch_data;
                        err_q   <= misaligned;
                        lat_cnt <= LAT_INIT;
                        state   <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt <= 4'd1) begin
                        lat_cnt <= '0;
                        state   <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state     <= IDLE;
                        inst_q    <= '0;
                        err_q     <= 1'b0;
                        fetch_cnt <= fetch_cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    lat_cnt <= '0;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_inst  = resp_valid ? inst_q : 32'd0;
    assign resp_err   = resp_valid & err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050854_imem_resp.sv
// ============================================================================
// Module   : tb_ysyx_22050854_imem_resp
// Brief    : Scoreboard bench for ysyx_22050854_imem_resp (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050854_imem_resp;

    localparam int DL  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [31:0]   req_pc = '0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_inst;
    logic          resp_err;
    logic          prog_wen = 1'b0;
    logic [DL-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic [31:0]   fetch_cnt;

    int n_total = 0;
    int n_pass  = 0;
    logic [32:0] exp_q [$];

    ysyx_22050854_imem_resp #(
        .DEPTH_LOG2(DL),
        .BASE_ADDR (32'h80000000),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_inst (resp_inst),
        .resp_err  (resp_err),
        .prog_wen  (prog_wen),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int idx, input logic [31:0] data);
        prog_wen  = 1'b1;
        prog_addr = DL'(idx);
        prog_data = data;
        tick();
        prog_wen  = 1'b0;
    endtask

    // mode 0: plain fetch; 1: program write at the accept edge; 2: write during first stall cycle
    task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ee,
                         input int stall, input int mode, input int widx, input logic [31:0] wdata);
        int k;
        logic [31:0] cnt0;
        logic [31:0] held;
        k = 0;
        while (!req_ready && k < 20) begin tick(); k++; end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        cnt0 = fetch_cnt;
        exp_q.push_back({ee, ei});
        req_valid = 1'b1;
        req_pc    = pc;
        if (mode == 1) begin
            prog_wen = 1'b1; prog_addr = DL'(widx); prog_data = wdata;
        end
        tick();
        req_valid = 1'b0;
        prog_wen  = 1'b0;
        k = 1;
        while (!resp_valid && k < 20) begin tick(); k++; end
        chk("latency", k, LAT);
        held = resp_inst;
        for (int i = 0; i < stall; i++) begin
            if (i == 0 && mode == 2) begin
                prog_wen = 1'b1; prog_addr = DL'(widx); prog_data = wdata;
            end
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_inst", resp_inst, held);
            chk("stall_cnt", fetch_cnt, cnt0);
            tick();
            prog_wen = 1'b0;
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("cnt_incr", fetch_cnt, cnt0 + 32'd1);
        chk("idle_after_hs", {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    // Monitor: pop on each response handshake; outputs must be zero when not valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_resp: got inst %08h err %0d expected none", resp_inst, resp_err);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("resp_inst", resp_inst, e[31:0]);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
                end
            end else if (!resp_valid) begin
                chk("zero_when_invalid", {resp_inst[31:1], resp_inst[0] | resp_err}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mis_inst;
        logic        mis_err;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_inst", resp_inst, 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        prog(0, 32'h00500293);
        prog(1, 32'h11111111);
        prog(1023, 32'hABCD0123);

        fetch(32'h80000000, 32'h00500293, 1'b0, 0, 0, 0, 32'd0);
        chk("cnt_first", fetch_cnt, 32'd1);
        // stalled response; write to the in-flight word must not disturb it
        fetch(32'h80000004, 32'h11111111, 1'b0, 5, 2, 1, 32'h22222222);
        fetch(32'h80000004, 32'h22222222, 1'b0, 0, 0, 0, 32'd0);
        fetch(32'h80001000, 32'h00100073, 1'b0, 0, 0, 0, 32'd0);
        fetch(32'h7FFFFFFC, 32'h00100073, 1'b0, 0, 0, 0, 32'd0);
        fetch(32'h80000FFC, 32'hABCD0123, 1'b0, 1, 0, 0, 32'd0);
`ifdef YSYX_22050854_IMEM_MISALIGN_CHK_EN
        mis_inst = 32'd0;        mis_err = 1'b1;
`else
        mis_inst = 32'h00500293; mis_err = 1'b0;
`endif
        fetch(32'h80000002, mis_inst, mis_err, 0, 0, 0, 32'd0);
        // same-edge program write to the fetched word returns the old word
        fetch(32'h80000000, 32'h00500293, 1'b0, 0, 1, 0, 32'hDEADBEEF);
        fetch(32'h80000000, 32'hDEADBEEF, 1'b0, 0, 0, 0, 32'd0);
        chk("cnt_before_rst", fetch_cnt, 32'd9);

        // reset in the WAIT cycle drops the in-flight fetch
        req_valid = 1'b1;
        req_pc    = 32'h80000004;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("async_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("async_rst_cnt", fetch_cnt, 32'd0);
        tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("dropped_no_valid", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        resp_ready = 1'b0;
        chk("dropped_cnt", fetch_cnt, 32'd0);
        chk("dropped_ready", {31'd0, req_ready}, 32'd1);

        // memory survives reset
        fetch(32'h80000000, 32'hDEADBEEF, 1'b0, 0, 0, 0, 32'd0);
        chk("cnt_after_rst", fetch_cnt, 32'd1);
        tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22050854_imem_resp.md
YSYX_22050854_IMEM_RESP -- requirements
Module: ysyx_22050854_imem_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of instruction words stored (1024 x 32).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h80000000, byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, legal 1..15, cycles from request accept to response valid.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  CPU presents fetch address.
REQ-007 SHALL have port req_pc  input  32  fetch byte address.
REQ-008 SHALL have port req_ready  output  1  responder can accept a request.
REQ-009 SHALL have port resp_valid  output  1  resp_inst/resp_err valid.
REQ-010 SHALL have port resp_ready  input  1  CPU consumes response.
REQ-011 SHALL have port resp_inst  output  32  fetched instruction.
REQ-012 SHALL have port resp_err  output  1  fetch fault (see Configuration).
REQ-013 SHALL have port prog_wen  input  1  program-load write strobe.
REQ-014 SHALL have port prog_addr  input  DEPTH_LOG2  word index to write.
REQ-015 SHALL have port prog_data  input  32  word to write.
REQ-016 SHALL have port fetch_cnt  output  32  completed response count.

Function
REQ-017 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 Accept = req_valid && req_ready at a rising edge; IDLE -> WAIT (LATENCY>1) or -> RESP (LATENCY=1), latency counter loaded LATENCY-1.
REQ-019 WAIT decrements counter each cycle; at 1 -> RESP, so resp_valid rises exactly LATENCY edges after accept edge.
REQ-020 RESP holds resp_valid, resp_inst, resp_err stable until resp_valid && resp_ready; that edge -> IDLE, fetch_cnt += 1 (wraps 2^32-1 -> 0).
REQ-021 One outstanding request max; a new request is never accepted in the response-handshake cycle; throughput one fetch per LATENCY+1 cycles with resp_ready held 1.
REQ-022 Memory word read at the accept edge into a holding register; later prog writes do not alter an in-flight response.
REQ-023 prog_wen write and accept to the same word at the same edge: response returns the old word.
REQ-024 Word index = (req_pc - BASE_ADDR) >> 2, 32-bit unsigned subtraction.
REQ-025 req_pc outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2): resp_inst = 32'h00100073 (ebreak), resp_err = 0; memory not read.
REQ-026 prog_wen accepted in any state, independent of fetch FSM; never stalls.
REQ-027 resp_inst and resp_err SHALL be 0 whenever resp_valid = 0.

Reset
REQ-028 rst asserted: immediately state IDLE, req_ready 1, resp_valid 0, resp_inst 0, resp_err 0, fetch_cnt 0, counter 0.
REQ-029 rst mid-WAIT or mid-RESP SHALL drop the in-flight response without handshake or fetch_cnt increment.
REQ-030 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-031 Macro YSYX_22050854_IMEM_MISALIGN_CHK_EN defined: accept with req_pc[1:0] != 0 yields resp_inst 0, resp_err 1, same latency; in-range check still applies to aligned pc only.
REQ-032 Macro undefined: req_pc[1:0] ignored (treated as 00), resp_err constant 0.

Verification
REQ-033 LATENCY=2; prog word 0 = 32'h00500293; req_pc 32'h80000000 accepted cycle N -> resp_valid at N+2, resp_inst 32'h00500293, fetch_cnt 1 after handshake.
REQ-034 resp_ready held 0 for 5 cycles in RESP -> resp_valid/resp_inst stable, req_ready 0, fetch_cnt unchanged; then resp_ready 1 -> IDLE next cycle.
REQ-035 req_pc 32'h80001000 (DEPTH_LOG2=10) -> resp_inst 32'h00100073, resp_err 0.
REQ-036 Macro defined, req_pc 32'h80000002 -> resp_inst 0, resp_err 1; macro undefined -> word 0 returned, resp_err 0.
REQ-037 Accept at cycle N, rst pulse at N+1 -> resp_valid never asserts, req_ready 1, fetch_cnt 0; same-edge prog write to word 0 with accept -> old word returned.
